foc_sequencer: RTL and testbench

FOC_SEQUENCER -- requirements
Module: foc_sequencer

---
 rtl/foc_sequencer.sv | 101 ++++++++++
 tb/tb_foc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/foc_sequencer.sv
// foc_sequencer: loads PID coefficients, then runs one FOC datapath cycle per control tick
// Ports: clk/rstb (async, active-high reset); enable, trig start a cycle;
//   adc_valid/adc_a/adc_b current sample; cfg_kp_*/cfg_ki_* shadow coefficients, cfg_update reload request;
//   err_clr clears sticky flags; pid_*_wen/addr/data coefficient writes; dp_valid/dp_currA/dp_currB
//   datapath start and held sample; dp_ready completion; busy, overrun_err, timeout_err, cycle_cnt status.
module foc_sequencer #(
  parameter int D_WIDTH = 19,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic               trig,
  input  logic               adc_valid,
  input  logic [D_WIDTH-1:0] adc_a,
  input  logic [D_WIDTH-1:0] adc_b,
  input  logic [D_WIDTH-1:0] cfg_kp_d,
  input  logic [D_WIDTH-1:0] cfg_ki_d,
  input  logic [D_WIDTH-1:0] cfg_kp_q,
  input  logic [D_WIDTH-1:0] cfg_ki_q,
  input  logic               cfg_update,
  input  logic               err_clr,
  output logic               pid_d_wen,
  output logic               pid_q_wen,
  output logic [D_WIDTH-1:0] pid_d_addr,
  output logic [D_WIDTH-1:0] pid_q_addr,
  output logic [D_WIDTH-1:0] pid_d_data,
  output logic [D_WIDTH-1:0] pid_q_data,
  output logic               dp_valid,
  output logic [D_WIDTH-1:0] dp_currA,
  output logic [D_WIDTH-1:0] dp_currB,
  input  logic               dp_ready,
  output logic               busy,
  output logic               overrun_err,
  output logic               timeout_err,
  output logic [15:0]        cycle_cnt
);
  typedef enum logic [2:0] {BOOT, CFG_KP, CFG_KI, IDLE, WAIT_ADC, ISSUE, WAIT_READY} state_t;
  state_t state, nxt;
  logic pending;
  logic [15:0] wd;
  logic expire, done, to_set, ov_set;
  // next state drives the registered outputs so they line up with the state they belong to
  always_comb begin
    nxt = state;
    case (state)
      BOOT:       nxt = CFG_KP;
      CFG_KP:     nxt = CFG_KI;
      CFG_KI:     nxt = IDLE;
      IDLE:       nxt = pending ? CFG_KP : (trig && enable) ? WAIT_ADC : IDLE;
      WAIT_ADC:   nxt = adc_valid ? ISSUE : WAIT_ADC;
      ISSUE:      nxt = WAIT_READY;
      WAIT_READY: nxt = (dp_ready || expire) ? IDLE : WAIT_READY;
      default:    nxt = BOOT;
    endcase
  end
  assign expire = wd == 16'(TIMEOUT - 1);
  assign done   = state == WAIT_READY && dp_ready;
  assign to_set = state == WAIT_READY && !dp_ready && expire;
  // a trig that cannot start a cycle (busy, or losing to a pending reload) is an overrun
  assign ov_set = trig && enable && (state != IDLE || pending);
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state       <= BOOT;
      pending     <= 1'b0;
      wd          <= '0;
      pid_d_wen   <= 1'b0;
      pid_q_wen   <= 1'b0;
      pid_d_addr  <= '0;
      pid_q_addr  <= '0;
      pid_d_data  <= '0;
      pid_q_data  <= '0;
      dp_valid    <= 1'b0;
      dp_currA    <= '0;
      dp_currB    <= '0;
      busy        <= 1'b0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      state       <= nxt;
      pending     <= cfg_update || (pending && state != IDLE);
      wd          <= (state == WAIT_READY) ? wd + 16'd1 : '0;
      pid_d_wen   <= nxt == CFG_KP || nxt == CFG_KI;
      pid_q_wen   <= nxt == CFG_KP || nxt == CFG_KI;
      pid_d_addr  <= (nxt == CFG_KI) ? D_WIDTH'(1) : '0;
      pid_q_addr  <= (nxt == CFG_KI) ? D_WIDTH'(1) : '0;
      pid_d_data  <= (nxt == CFG_KP) ? cfg_kp_d : (nxt == CFG_KI) ? cfg_ki_d : '0;
      pid_q_data  <= (nxt == CFG_KP) ? cfg_kp_q : (nxt == CFG_KI) ? cfg_ki_q : '0;
      dp_valid    <= nxt == ISSUE;
      busy        <= nxt != BOOT && nxt != IDLE;
      overrun_err <= ov_set || (overrun_err && !err_clr);
      timeout_err <= to_set || (timeout_err && !err_clr);
      cycle_cnt   <= cycle_cnt + 16'(done);
      if (state == WAIT_ADC && adc_valid) begin
        dp_currA <= adc_a;
        dp_currB <= adc_b;
      end
    end
  end
endmodule

// File: tb/tb_foc_sequencer.sv
// tb_foc_sequencer: randomized scoreboard bench for foc_sequencer
module tb_foc_sequencer;
  localparam int DW = 19;
  localparam int TO = 8;
  logic clk = 0, rstb = 0, enable = 0, trig = 0, adc_valid = 0, cfg_update = 0, err_clr = 0, dp_ready = 0;
  logic [DW-1:0] adc_a = 0, adc_b = 0, cfg_kp_d = 0, cfg_ki_d = 0, cfg_kp_q = 0, cfg_ki_q = 0;
  logic pid_d_wen, pid_q_wen, dp_valid, busy, overrun_err, timeout_err;
  logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data, dp_currA, dp_currB;
  logic [15:0] cycle_cnt;
  always #5 clk = ~clk;
  foc_sequencer #(.D_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .trig(trig), .adc_valid(adc_valid), .adc_a(adc_a),
    .adc_b(adc_b), .cfg_kp_d(cfg_kp_d), .cfg_ki_d(cfg_ki_d), .cfg_kp_q(cfg_kp_q), .cfg_ki_q(cfg_ki_q),
    .cfg_update(cfg_update), .err_clr(err_clr), .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
    .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr), .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
    .dp_valid(dp_valid), .dp_currA(dp_currA), .dp_currB(dp_currB), .dp_ready(dp_ready), .busy(busy),
    .overrun_err(overrun_err), .timeout_err(timeout_err), .cycle_cnt(cycle_cnt)
  );
  typedef struct packed {logic [DW-1:0] addr, dd, qd;} wr_t;
  wr_t exp_wr[$];
  logic [2*DW-1:0] exp_dp[$];
  logic [15:0] exp_cnt[$];
  int checks = 0, errors = 0;
  logic [15:0] m_cnt = 0;
  logic m_ov = 0, m_to = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_cfg;
    exp_wr.push_back('{addr: DW'(0), dd: cfg_kp_d, qd: cfg_kp_q});
    exp_wr.push_back('{addr: DW'(1), dd: cfg_ki_d, qd: cfg_ki_q});
  endtask
  task automatic wait_idle(input int n);
    for (int i = 0; i < n && busy; i++) tick();
    chk("busy_low", busy, 0);
  endtask
  // monitor: every write, datapath start and count change must match the next queued expectation
  logic [15:0] prev_cnt = 0;
  wr_t w;
  logic [2*DW-1:0] d;
  always @(negedge clk) begin
    if (pid_d_wen || pid_q_wen) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: addr %0h data %0h", pid_d_addr, pid_d_data);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_wen", {pid_d_wen, pid_q_wen}, 2'b11);
        chk("wr_d_addr", pid_d_addr, w.addr);
        chk("wr_q_addr", pid_q_addr, w.addr);
        chk("wr_d_data", pid_d_data, w.dd);
        chk("wr_q_data", pid_q_data, w.qd);
      end
    end else chk("wr_quiet", |{pid_d_addr, pid_q_addr, pid_d_data, pid_q_data}, 0);
    if (dp_valid) begin
      if (exp_dp.size() == 0) begin
        checks++; errors++;
        $display("FAIL dp_unexpected: currA %0h currB %0h", dp_currA, dp_currB);
      end else begin
        d = exp_dp.pop_front();
        chk("dp_currA", dp_currA, d[2*DW-1:DW]);
        chk("dp_currB", dp_currB, d[DW-1:0]);
      end
    end
    if (cycle_cnt !== prev_cnt && !rstb) begin
      if (exp_cnt.size() == 0) begin
        checks++; errors++;
        $display("FAIL cnt_unexpected: got %0h", cycle_cnt);
      end else chk("cycle_cnt_step", cycle_cnt, exp_cnt.pop_front());
    end
    prev_cnt = cycle_cnt;
  end
  task automatic check_reset_outputs;
    chk("rst_wen", {pid_d_wen, pid_q_wen}, 0);
    chk("rst_wr", |{pid_d_addr, pid_q_addr, pid_d_data, pid_q_data}, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_curr", {dp_currA, dp_currB}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overrun_err, timeout_err}, 0);
    chk("rst_cnt", cycle_cnt, 0);
  endtask
  task automatic check_status(input logic [DW-1:0] a, input logic [DW-1:0] b);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("overrun_err", overrun_err, m_ov);
    chk("timeout_err", timeout_err, m_to);
    chk("hold_currA", dp_currA, a);
    chk("hold_currB", dp_currB, b);
  endtask
  // k: cycle of dp_ready counted from entry to WAIT_READY; k = TO+1 means it arrives too late
  task automatic run_cycle(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap, input int k,
                           input bit xtrig, input bit upd, input bit clr_to);
    enable = 1;
    trig = 1;
    tick();
    trig = 0;
    chk("busy_after_trig", busy, 1);
    repeat (gap) tick();
    adc_a = a;
    adc_b = b;
    adc_valid = 1;
    exp_dp.push_back({a, b});
    tick();
    adc_valid = 0;
    adc_a = DW'($urandom);
    adc_b = DW'($urandom);
    tick();
    if (upd) begin
      cfg_kp_d = DW'($urandom);
      cfg_ki_d = DW'($urandom);
      cfg_kp_q = DW'($urandom);
      cfg_ki_q = DW'($urandom);
      cfg_update = 1;
      push_cfg();
    end
    for (int j = 1; j < k; j++) begin
      if (xtrig && j == 1) begin
        trig = 1;
        enable = 1'($urandom_range(0, 1));
        m_ov = m_ov | enable;
      end
      if (clr_to && j == TO) begin
        err_clr = 1;
        m_ov = 0;
      end
      tick();
      trig = 0;
      enable = 1;
      err_clr = 0;
      cfg_update = 0;
    end
    dp_ready = 1;
    tick();
    dp_ready = 0;
    cfg_update = 0;
    if (k <= TO) begin
      m_cnt = m_cnt + 16'd1;
      exp_cnt.push_back(m_cnt);
    end else m_to = 1;
    if (upd) begin
      trig = 1;
      tick();
      trig = 0;
      m_ov = 1;
    end
    wait_idle(12);
    check_status(a, b);
  endtask
  task automatic clear_errs;
    err_clr = 1;
    tick();
    err_clr = 0;
    m_ov = 0;
    m_to = 0;
    chk("err_clr", {overrun_err, timeout_err}, 0);
  endtask
  initial begin
    cfg_kp_d = 4096; cfg_kp_q = 4096;
    cfg_ki_d = 512;  cfg_ki_q = 512;
    #2 rstb = 1;
    #1 check_reset_outputs();
    tick();
    push_cfg();
    rstb = 0;
    tick();
    wait_idle(10);
    chk("boot_writes_done", exp_wr.size(), 0);
    run_cycle(19'd16384, 19'h7C000, 1, TO, 0, 0, 0);
    run_cycle(DW'($urandom), DW'($urandom), 0, TO + 1, 0, 0, 0);
    clear_errs();
    run_cycle(DW'($urandom), DW'($urandom), 2, 5, 1, 0, 0);
    run_cycle(DW'($urandom), DW'($urandom), 0, 3, 0, 1, 0);
    run_cycle(DW'($urandom), DW'($urandom), 1, TO + 1, 1, 0, 1);
    clear_errs();
    enable = 0;
    trig = 1;
    tick();
    trig = 0;
    enable = 1;
    chk("trig_disabled_busy", busy, 0);
    chk("trig_disabled_ov", overrun_err, 0);
    for (int i = 0; i < 30; i++) begin
      run_cycle(DW'($urandom), DW'($urandom), $urandom_range(0, 4), $urandom_range(1, TO + 1),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) clear_errs();
    end
    enable = 1;
    trig = 1;
    tick();
    trig = 0;
    tick();
    #2 rstb = 1;
    #1 check_reset_outputs();
    m_cnt = 0;
    m_ov = 0;
    m_to = 0;
    tick();
    tick();
    push_cfg();
    rstb = 0;
    tick();
    wait_idle(10);
    chk("reload_writes_done", exp_wr.size(), 0);
    run_cycle(DW'($urandom), DW'($urandom), 0, 4, 0, 0, 0);
    repeat (3) tick();
    chk("q_wr_empty", exp_wr.size(), 0);
    chk("q_dp_empty", exp_dp.size(), 0);
    chk("q_cnt_empty", exp_cnt.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
